// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command initiator and its helpers.
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int APB_ADDR_W      = 32;
    localparam int DEFAULT_TIMEOUT = 16;

    // A limit of 0 means "never expire"; keep at least one bit so the counter stays legal.
    function automatic int timer_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter with synchronous clear/enable and an expired flag.
module apb_wait_timer
    import apb_cmd_master_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = timer_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);

    logic [CW-1:0] r_count;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAX)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Flags the final permitted wait cycle so the caller can abort on that edge.
    assign o_expired = (LIMIT != 0) && (r_count == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer out, one response back.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [WIDTH-1:0]      pwdata,
    input  logic [WIDTH-1:0]      prdata,
    input  logic                  pready
);

    state_t                r_state;
    logic [APB_ADDR_W-1:0] r_paddr;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [WIDTH-1:0]      r_pwdata;
    logic                  r_rsp_valid;
    logic [WIDTH-1:0]      r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  w_expired;

    apb_wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .i_clr     (r_state == ST_SETUP),
        .i_en      ((r_state == ST_ACCESS) && !pready),
        .o_expired (w_expired)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= ST_IDLE;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_paddr   <= cmd_addr;
                        r_pwrite  <= cmd_write;
                        r_pwdata  <= cmd_write ? cmd_wdata : '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (w_expired) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Address/data stay parked; only psel qualifies them on the bus.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign paddr     = r_paddr;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
